// File: rtl/karat_mult_seq.sv
// ---------------------------------------------------------------------------
// karat_mult_seq
//
// Sequential Karatsuba multiplier: WIDTH x WIDTH -> 2*WIDTH product.
// One (SPLIT+1) x (SPLIT+1) multiplier is time-shared across the three
// Karatsuba sub-products p = ah*bh, q = al*bl and t = (ah+al)*(bh+bl).
// The partial results are then combined as
//     product = (p << WIDTH) + ((t - p - q) << SPLIT) + q.
//
// Sequence: IDLE -> MUL_P -> MUL_Q -> MUL_T -> COMBINE -> DONE -> IDLE.
// Handshake at edge E0 gives out_valid high after E4. The minimum
// initiation interval is 6 cycles.
//
// Optional build macro:
//   KARAT_SIGNED_EN - operands are two's complement. Magnitudes are
//                     multiplied and the result is negated when the
//                     operand signs differ. Latency and handshake are
//                     unchanged.
//
// Ports:
//   clk_in       system clock
//   rst_in       asynchronous reset, active-high
//   a_in, b_in   operands, captured when in_valid && in_ready
//   in_valid     operands valid
//   in_ready     block can accept operands (IDLE and not in reset)
//   product_out  registered product, stable while DONE
//   out_valid    product_out valid
//   out_ready    downstream accepts product
//   busy_out     high in any state other than IDLE
// ---------------------------------------------------------------------------
module karat_mult_seq #(
    parameter int WIDTH = 64
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2*WIDTH-1:0]   product_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy_out
);

    localparam int SPLIT = WIDTH / 2;
    localparam int MW    = SPLIT + 1;      // shared multiplier operand width
    localparam int PW    = 2 * SPLIT;      // width of p and q
    localparam int TW    = 2 * SPLIT + 2;  // width of t and m
    localparam int OW    = 2 * WIDTH;      // product width

    generate
        if ((WIDTH % 2 != 0) || (WIDTH < 4)) begin : g_bad_width
            $error("karat_mult_seq: WIDTH must be even and >= 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        MUL_P,
        MUL_Q,
        MUL_T,
        COMBINE,
        DONE
    } state_t;

    state_t state, state_next;

    logic [SPLIT-1:0] ah, al, bh, bl;
    logic [PW-1:0]    p, q;
    logic [TW-1:0]    t;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic             accept;

    assign in_ready  = (state == IDLE) && !rst_in;
    assign busy_out  = (state != IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

`ifdef KARAT_SIGNED_EN
    // Magnitudes of the two's complement operands. The most negative value
    // wraps onto itself, which read as unsigned is exactly 2^(WIDTH-1).
    logic neg;
    assign a_mag = a_in[WIDTH-1] ? (~a_in + WIDTH'(1)) : a_in;
    assign b_mag = b_in[WIDTH-1] ? (~b_in + WIDTH'(1)) : b_in;
`else
    assign a_mag = a_in;
    assign b_mag = b_in;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: every clocked register uses non-blocking assignments so all
    // flops sample pre-edge values regardless of statement order.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: state_next is defaulted before the case so no path through
    // this block leaves it unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = MUL_P;
            MUL_P:   state_next = MUL_Q;
            MUL_Q:   state_next = MUL_T;
            MUL_T:   state_next = COMBINE;
            COMBINE: state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Shared multiplier: operand mux selects the sub-product for the
    // current state. The (ah+al) and (bh+bl) sums keep their carry bit.
    // ------------------------------------------------------------------
    logic [MW-1:0] mul_a, mul_b;
    logic [TW-1:0] mul_res;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        unique case (state)
            MUL_P: begin
                mul_a = {1'b0, ah};
                mul_b = {1'b0, bh};
            end
            MUL_Q: begin
                mul_a = {1'b0, al};
                mul_b = {1'b0, bl};
            end
            MUL_T: begin
                mul_a = {1'b0, ah} + {1'b0, al};
                mul_b = {1'b0, bh} + {1'b0, bl};
            end
            default: ;
        endcase
    end

    assign mul_res = TW'(mul_a) * TW'(mul_b);

    // ------------------------------------------------------------------
    // Karatsuba recombination. m = t - p - q is never negative, and the
    // sum always fits in 2*WIDTH bits.
    // ------------------------------------------------------------------
    logic [TW-1:0] m;
    logic [OW-1:0] sum;
    logic [OW-1:0] product_next;

    assign m   = t - TW'(p) - TW'(q);
    assign sum = (OW'(p) << WIDTH) + (OW'(m) << SPLIT) + OW'(q);

`ifdef KARAT_SIGNED_EN
    assign product_next = neg ? (~sum + OW'(1)) : sum;
`else
    assign product_next = sum;
`endif

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // NOTE: the operand and partial registers are plain flops, not memory,
    // so they are reset too; an aborted operation leaves nothing behind.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ah          <= '0;
            al          <= '0;
            bh          <= '0;
            bl          <= '0;
            p           <= '0;
            q           <= '0;
            t           <= '0;
            product_out <= '0;
`ifdef KARAT_SIGNED_EN
            neg         <= 1'b0;
`endif
        end else begin
            if (accept) begin
                {ah, al} <= a_mag;
                {bh, bl} <= b_mag;
`ifdef KARAT_SIGNED_EN
                neg      <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
`endif
            end
            // The top two bits of mul_res are zero for p and q.
            if (state == MUL_P)   p           <= mul_res[PW-1:0];
            if (state == MUL_Q)   q           <= mul_res[PW-1:0];
            if (state == MUL_T)   t           <= mul_res;
            if (state == COMBINE) product_out <= product_next;
        end
    end

endmodule

// File: doc/karat_mult_seq.md
Name: karat_mult_seq

Overview:
- Sequential, parametrised Karatsuba multiplier for the keychain datapath, for example as the modular-exponentiation product unit.
- Computes a WIDTH x WIDTH -> 2*WIDTH product by time-sharing one (SPLIT+1)-bit multiplier across the three Karatsuba sub-products.
- Operands and product move over valid/ready handshakes with full output backpressure.
- Trades throughput for area relative to a fully combinational three-multiplier Karatsuba.

Parameters:
- WIDTH, 64, operand width in bits. Must be even and >= 4; violation is an elaboration error.
- SPLIT, WIDTH/2, half-width. Derived localparam; not overridable.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous reset, active-high
- a_in  input  WIDTH  operand A
- b_in  input  WIDTH  operand B
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- product_out  output  2*WIDTH  registered product
- out_valid  output  1  product_out valid
- out_ready  input  1  downstream accepts product
- busy_out  output  1  high in any state other than IDLE

Behaviour:
- Reset is asynchronous and active-high on rst_in. While asserted:
  - state = IDLE;
  - product_out = 0, out_valid = 0, in_ready = 0, busy_out = 0;
  - all internal operand and partial registers = 0.
- in_ready = (state == IDLE) && !rst_in. It is combinational from state only, with no dependence on in_valid.
- Operand split: a_in = {ah, al}, b_in = {bh, bl}, each half SPLIT bits. Operands are captured on the clock edge where in_valid && in_ready.
- FSM: IDLE -> MUL_P -> MUL_Q -> MUL_T -> COMBINE -> DONE -> IDLE. Each arrow is one clock edge except where noted.
  - IDLE: on handshake, latch ah, al, bh, bl; go to MUL_P.
  - MUL_P: p = ah*bh, zero-extended into the shared multiplier; p is 2*SPLIT bits.
  - MUL_Q: q = al*bl, 2*SPLIT bits.
  - MUL_T: r = ah+al and s = bh+bl, each SPLIT+1 bits. t = r*s, 2*SPLIT+2 bits.
  - COMBINE: m = t - p - q, computed at 2*SPLIT+2 bits; m is never negative. Register product_out = (p << WIDTH) + (m << SPLIT) + q, truncated to 2*WIDTH (no overflow is possible). Go to DONE.
  - DONE: out_valid = 1. product_out holds stable while out_valid && !out_ready. On out_valid && out_ready, go to IDLE and clear out_valid on that edge.
- Latency and throughput:
  - With the handshake at edge E0, out_valid is high after edge E4.
  - in_ready returns the cycle after the output handshake.
  - Minimum initiation interval is 6 cycles.
- Exactly one multiplier instance of (SPLIT+1) x (SPLIT+1) bits exists. The three sub-products are muxed into it.
- Boundary behaviour:
  - in_valid is ignored outside IDLE; operands change freely with no effect.
  - Backpressure is unlimited; DONE holds indefinitely.
  - r/s carries (for example ah = al = all-ones) must be exact; the SPLIT+1-bit width is mandatory.
  - Asserting rst_in in any state aborts the operation immediately and discards any pending result. No out_valid is produced for an aborted operation.

Optional Feature:
- Macro: KARAT_SIGNED_EN.
- Defined: a_in and b_in are two's complement.
  - At capture, store |a_in|, |b_in| (WIDTH-bit unsigned; -2^(WIDTH-1) maps to 2^(WIDTH-1)) and sign flag neg = a_sign ^ b_sign.
  - In COMBINE, product_out is negated (two's complement, 2*WIDTH bits) if neg.
  - Latency and handshake are unchanged.
- Undefined: unsigned operands only. No sign logic or neg register is present.

Test Plan:
- WIDTH=8, a=0xFF, b=0xFF -> product_out=0xFE01, out_valid high 4 edges after handshake, in_ready low throughout.
- WIDTH=64, a=b=0xFFFF_FFFF_FFFF_FFFF -> product_out=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001; a=0x1_0000_0000, b=0x1_0000_0000 -> product_out=2^64.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> product_out stable, in_valid pulses ignored; out_ready=1 -> one transfer, in_ready=1 next cycle.
- Back-to-back operations with out_ready tied 1, 100 random 64-bit pairs -> every product matches the reference model, 6-cycle spacing; a=0 or b=0 -> 0.
- Reset asserted asynchronously during MUL_T -> out_valid=0, product_out=0, busy_out=0 immediately. After release, a=3, b=5 -> 15.
- KARAT_SIGNED_EN, WIDTH=8:
  - -1 * -1 -> 0x0001
  - -3 * 5 -> 0xFFF1
  - -128 * -128 -> 0x4000
  - -128 * 127 -> 0xC080
